// File: rtl/waypoint_sequencer.sv
// Waypoint sequencer: steps through a table of target poses, emits the registered
// sign-magnitude pose error, and advances/faults based on the returned velocity command.
module waypoint_sequencer #(
  parameter int unsigned N_WIDTH        = 17,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned SETTLE_CYCLES  = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic                WAYPOINT_SEQUENCER_CLOCK_50,
  input  logic                WAYPOINT_SEQUENCER_RESET_InHigh,
  input  logic                WAYPOINT_SEQUENCER_START_In,
  input  logic                WAYPOINT_SEQUENCER_ABORT_In,
  input  logic [ADDR_W:0]     WAYPOINT_SEQUENCER_WP_COUNT_InBus,
  input  logic                WAYPOINT_SEQUENCER_WR_EN_In,
  input  logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_WR_ADDR_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WR_X_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WR_Y_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WR_Z_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_X_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_Y_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_Z_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_VX_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_VY_InBus,
  input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WZ_InBus,
  output logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_X_OutBus,
  output logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_Y_OutBus,
  output logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_Z_OutBus,
  output logic                WAYPOINT_SEQUENCER_MOTION_EN_Out,
  output logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_INDEX_OutBus,
  output logic                WAYPOINT_SEQUENCER_BUSY_Out,
  output logic                WAYPOINT_SEQUENCER_DONE_Out,
  output logic                WAYPOINT_SEQUENCER_FAULT_Out
);

  localparam int unsigned           MW          = N_WIDTH - 1;
  localparam int unsigned           SW          = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SW-1:0]         SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [31:0]           TIMEOUT_MAX = 32'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W:0]       DEPTH_CNT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [N_WIDTH-1:0]    MAG_MASK    = {1'b0, {MW{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TRACK, S_ADVANCE, S_DONE, S_FAULT} state_t;

  state_t               r_state, w_next;
  logic [ADDR_W-1:0]    r_index;
  logic [ADDR_W:0]      r_count;
  logic [SW-1:0]        r_settle;
  logic [31:0]          r_timeout;
  logic                 r_first;
  logic [N_WIDTH-1:0]   r_tgt_x, r_tgt_y, r_tgt_z;
  logic [N_WIDTH-1:0]   r_err_x, r_err_y, r_err_z;
  logic [N_WIDTH-1:0]   r_tbl_x [DEPTH];
  logic [N_WIDTH-1:0]   r_tbl_y [DEPTH];
  logic [N_WIDTH-1:0]   r_tbl_z [DEPTH];

  logic                 w_idle_like, w_start_ok, w_last, w_vzero, w_timeout, w_settled;
  logic [ADDR_W:0]      w_count_in;

  // target - pose in two's complement, back to sign-magnitude with saturation; zero is +0
  function automatic logic [N_WIDTH-1:0] sm_sub(input logic [N_WIDTH-1:0] a,
                                                input logic [N_WIDTH-1:0] b);
    logic signed [MW+1:0] ta, tb, d;
    logic [MW+1:0]        mag;
    logic [N_WIDTH-1:0]   res;
    ta  = a[MW] ? -$signed({2'b00, a[MW-1:0]}) : $signed({2'b00, a[MW-1:0]});
    tb  = b[MW] ? -$signed({2'b00, b[MW-1:0]}) : $signed({2'b00, b[MW-1:0]});
    d   = ta - tb;
    mag = d[MW+1] ? $unsigned(-d) : $unsigned(d);
    res[MW]     = d[MW+1];
    res[MW-1:0] = (mag[MW+1:MW] != 2'b00) ? '1 : mag[MW-1:0];
    return res;
  endfunction

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAULT);
  assign w_start_ok  = WAYPOINT_SEQUENCER_START_In && !WAYPOINT_SEQUENCER_ABORT_In && w_idle_like;
  assign w_count_in  = (WAYPOINT_SEQUENCER_WP_COUNT_InBus > DEPTH_CNT) ? DEPTH_CNT
                                                                         : WAYPOINT_SEQUENCER_WP_COUNT_InBus;
  assign w_last      = ({1'b0, r_index} + (ADDR_W + 1)'(1)) == r_count;
  assign w_vzero     = ((WAYPOINT_SEQUENCER_VX_InBus & MAG_MASK) == '0) &&
                       ((WAYPOINT_SEQUENCER_VY_InBus & MAG_MASK) == '0) &&
                       ((WAYPOINT_SEQUENCER_WZ_InBus & MAG_MASK) == '0);
  assign w_timeout   = (r_timeout == TIMEOUT_MAX);
  assign w_settled   = (r_settle == SETTLE_MAX);

  always_ff @(posedge WAYPOINT_SEQUENCER_CLOCK_50) begin
    if (WAYPOINT_SEQUENCER_RESET_InHigh) r_state <= S_IDLE;
    else                                 r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (WAYPOINT_SEQUENCER_ABORT_In) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAULT:
          if (WAYPOINT_SEQUENCER_START_In) w_next = (w_count_in == '0) ? S_DONE : S_LOAD;
        S_LOAD:    w_next = S_TRACK;
        S_TRACK: begin
          if (w_timeout)      w_next = S_FAULT;
          else if (w_settled) w_next = S_ADVANCE;
        end
        S_ADVANCE: w_next = w_last ? S_DONE : S_LOAD;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Table is deliberately outside reset so programmed waypoints survive it
  always_ff @(posedge WAYPOINT_SEQUENCER_CLOCK_50) begin
    if (WAYPOINT_SEQUENCER_WR_EN_In && w_idle_like) begin
      r_tbl_x[WAYPOINT_SEQUENCER_WR_ADDR_InBus] <= WAYPOINT_SEQUENCER_WR_X_InBus;
      r_tbl_y[WAYPOINT_SEQUENCER_WR_ADDR_InBus] <= WAYPOINT_SEQUENCER_WR_Y_InBus;
      r_tbl_z[WAYPOINT_SEQUENCER_WR_ADDR_InBus] <= WAYPOINT_SEQUENCER_WR_Z_InBus;
    end
  end

  always_ff @(posedge WAYPOINT_SEQUENCER_CLOCK_50) begin
    if (WAYPOINT_SEQUENCER_RESET_InHigh) begin
      r_index   <= '0;
      r_count   <= '0;
      r_settle  <= '0;
      r_timeout <= '0;
      r_first   <= 1'b0;
      r_tgt_x   <= '0;
      r_tgt_y   <= '0;
      r_tgt_z   <= '0;
      r_err_x   <= '0;
      r_err_y   <= '0;
      r_err_z   <= '0;
    end else begin
      r_err_x <= '0;
      r_err_y <= '0;
      r_err_z <= '0;
      case (r_state)
        S_LOAD: begin
          r_tgt_x   <= r_tbl_x[r_index];
          r_tgt_y   <= r_tbl_y[r_index];
          r_tgt_z   <= r_tbl_z[r_index];
          r_settle  <= '0;
          r_timeout <= '0;
          r_first   <= 1'b1;
        end
        S_TRACK: begin
          r_err_x   <= sm_sub(r_tgt_x, WAYPOINT_SEQUENCER_POSE_X_InBus);
          r_err_y   <= sm_sub(r_tgt_y, WAYPOINT_SEQUENCER_POSE_Y_InBus);
          r_err_z   <= sm_sub(r_tgt_z, WAYPOINT_SEQUENCER_POSE_Z_InBus);
          r_first   <= 1'b0;
          r_timeout <= r_timeout + 32'd1;
          // first TRACK cycle has no valid error yet, so it never counts toward settling
          if (r_first || !w_vzero) r_settle <= '0;
          else                     r_settle <= r_settle + SW'(1);
        end
        S_ADVANCE: if (!w_last) r_index <= r_index + ADDR_W'(1);
        default: begin
          if (w_start_ok) begin
            r_index <= '0;
            r_count <= w_count_in;
          end
        end
      endcase
      if (WAYPOINT_SEQUENCER_ABORT_In) r_index <= '0;
    end
  end

  assign WAYPOINT_SEQUENCER_ERR_X_OutBus   = (r_state == S_TRACK) ? r_err_x : '0;
  assign WAYPOINT_SEQUENCER_ERR_Y_OutBus   = (r_state == S_TRACK) ? r_err_y : '0;
  assign WAYPOINT_SEQUENCER_ERR_Z_OutBus   = (r_state == S_TRACK) ? r_err_z : '0;
  assign WAYPOINT_SEQUENCER_MOTION_EN_Out  = (r_state == S_TRACK);
  assign WAYPOINT_SEQUENCER_INDEX_OutBus   = r_index;
  assign WAYPOINT_SEQUENCER_BUSY_Out       = (r_state == S_LOAD) || (r_state == S_TRACK) ||
                                             (r_state == S_ADVANCE);
  assign WAYPOINT_SEQUENCER_DONE_Out       = (r_state == S_DONE);
  assign WAYPOINT_SEQUENCER_FAULT_Out      = (r_state == S_FAULT);

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Directed self-checking bench for waypoint_sequencer with reduced settle/timeout windows.
module tb_waypoint_sequencer;

  localparam int unsigned S = 4;
  localparam int unsigned T = 40;

  logic        clk, rst, start, abort, wr_en;
  logic [3:0]  wp_count;
  logic [2:0]  wr_addr;
  logic [16:0] wr_x, wr_y, wr_z, pose_x, pose_y, pose_z, vx, vy, wz;
  logic [16:0] err_x, err_y, err_z;
  logic        motion, busy, done, fault;
  logic [2:0]  idx;

  int n_checks = 0;
  int n_errors = 0;
  int k;

  waypoint_sequencer #(
    .N_WIDTH(17), .DEPTH(8), .ADDR_W(3), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .WAYPOINT_SEQUENCER_CLOCK_50      (clk),
    .WAYPOINT_SEQUENCER_RESET_InHigh  (rst),
    .WAYPOINT_SEQUENCER_START_In      (start),
    .WAYPOINT_SEQUENCER_ABORT_In      (abort),
    .WAYPOINT_SEQUENCER_WP_COUNT_InBus(wp_count),
    .WAYPOINT_SEQUENCER_WR_EN_In      (wr_en),
    .WAYPOINT_SEQUENCER_WR_ADDR_InBus (wr_addr),
    .WAYPOINT_SEQUENCER_WR_X_InBus    (wr_x),
    .WAYPOINT_SEQUENCER_WR_Y_InBus    (wr_y),
    .WAYPOINT_SEQUENCER_WR_Z_InBus    (wr_z),
    .WAYPOINT_SEQUENCER_POSE_X_InBus  (pose_x),
    .WAYPOINT_SEQUENCER_POSE_Y_InBus  (pose_y),
    .WAYPOINT_SEQUENCER_POSE_Z_InBus  (pose_z),
    .WAYPOINT_SEQUENCER_VX_InBus      (vx),
    .WAYPOINT_SEQUENCER_VY_InBus      (vy),
    .WAYPOINT_SEQUENCER_WZ_InBus      (wz),
    .WAYPOINT_SEQUENCER_ERR_X_OutBus  (err_x),
    .WAYPOINT_SEQUENCER_ERR_Y_OutBus  (err_y),
    .WAYPOINT_SEQUENCER_ERR_Z_OutBus  (err_z),
    .WAYPOINT_SEQUENCER_MOTION_EN_Out (motion),
    .WAYPOINT_SEQUENCER_INDEX_OutBus  (idx),
    .WAYPOINT_SEQUENCER_BUSY_Out      (busy),
    .WAYPOINT_SEQUENCER_DONE_Out      (done),
    .WAYPOINT_SEQUENCER_FAULT_Out     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [16:0] x, input logic [16:0] y,
                    input logic [16:0] z);
    wr_en = 1'b1; wr_addr = a; wr_x = x; wr_y = y; wr_z = z;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] cnt);
    start = 1'b1; wp_count = cnt;
    step();
    start = 1'b0;
  endtask

  task automatic wait_motion(input string tag);
    int n = 0;
    while (motion !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(motion), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0; wp_count = '0; wr_addr = '0;
    wr_x = '0; wr_y = '0; wr_z = '0; pose_x = '0; pose_y = '0; pose_z = '0;
    vx = '0; vy = '0; wz = '0;
    @(negedge clk);
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_motion", 32'(motion), 0);
    chk("rst_index", 32'(idx), 0);
    chk("rst_err_x", 32'(err_x), 0);
    rst = 1'b0;

    // Single waypoint, zero command
    wr(3'd0, 17'h00100, 17'h00200, 17'h00000);
    wr(3'd1, 17'h0FF00, 17'h10000, 17'h00005);
    wr(3'd2, 17'h00010, 17'h10050, 17'h1FFFF);
    pulse_start(4'd1);
    chk("load_busy", 32'(busy), 1);
    chk("load_motion", 32'(motion), 0);
    step();
    chk("trk1_motion", 32'(motion), 1);
    chk("trk1_err_x_notvalid", 32'(err_x), 0);
    k = 0;
    step(); k++;
    chk("a_err_x", 32'(err_x), 32'h00100);
    chk("a_err_y", 32'(err_y), 32'h00200);
    chk("a_err_z", 32'(err_z), 32'h00000);
    while (done !== 1'b1 && k < 50) begin step(); k++; end
    chk("a_dwell", k, S + 3);
    chk("a_done", 32'(done), 1);
    chk("a_done_motion", 32'(motion), 0);
    chk("a_done_err_x", 32'(err_x), 0);
    chk("a_done_busy", 32'(busy), 0);
    chk("a_done_index", 32'(idx), 0);

    // Three waypoints with arithmetic corner cases and a settle glitch on waypoint 1
    pose_x = 17'h1FF00; pose_y = 17'h00000; pose_z = 17'h00007;
    pulse_start(4'd3);
    for (int wp = 0; wp < 3; wp++) begin
      wait_motion("b_track");
      chk("b_index", 32'(idx), 32'(wp));
      k = 0;
      step(); k++;
      if (wp == 0) begin
        chk("b0_err_x_sat", 32'(err_x), 32'h0FFFF);
        chk("b0_err_y", 32'(err_y), 32'h00200);
        chk("b0_err_z_neg", 32'(err_z), 32'h10007);
      end else if (wp == 1) begin
        chk("b1_err_x_sat", 32'(err_x), 32'h0FFFF);
        chk("b1_err_y_negzero", 32'(err_y), 32'h00000);
        chk("b1_err_z", 32'(err_z), 32'h10002);
        step(); k++;
        vx = 17'h00001;
        step(); k++;
        vx = 17'h00000;
      end else begin
        chk("b2_err_x", 32'(err_x), 32'h0FF10);
        chk("b2_err_y", 32'(err_y), 32'h10050);
        chk("b2_err_z_negsat", 32'(err_z), 32'h1FFFF);
      end
      while (motion === 1'b1 && k < 40) begin step(); k++; end
      chk("b_track_len", k, (wp == 1) ? S + 4 : S + 2);
      chk("b_adv_busy", 32'(busy), 1);
      chk("b_adv_err_x", 32'(err_x), 0);
    end
    step();
    chk("b_done", 32'(done), 1);
    chk("b_done_index", 32'(idx), 2);

    // START and ABORT together from DONE
    start = 1'b1; abort = 1'b1; wp_count = 4'd1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("c_done", 32'(done), 0);
    chk("c_busy", 32'(busy), 0);
    chk("c_index", 32'(idx), 0);
    step();
    chk("c_busy2", 32'(busy), 0);

    // Timeout with write attempt while busy and one-cycle error lag
    pose_x = '0; pose_y = '0; pose_z = '0; vx = 17'h00003;
    pulse_start(4'd1);
    wait_motion("d_track");
    k = 0;
    step(); k++;
    chk("d_err_x", 32'(err_x), 32'h00100);
    pose_x = 17'h00050;
    wr(3'd0, 17'h00777, 17'h00999, 17'h00000);
    k++;
    chk("d_err_lag", 32'(err_x), 32'h000B0);
    while (fault !== 1'b1 && k < 100) begin step(); k++; end
    chk("d_timeout_len", k, T + 1);
    chk("d_fault", 32'(fault), 1);
    chk("d_busy", 32'(busy), 0);
    chk("d_motion", 32'(motion), 0);
    chk("d_index", 32'(idx), 0);
    chk("d_err_x", 32'(err_x), 0);

    // Restart from FAULT: busy write must not have landed
    vx = '0; pose_x = '0;
    pulse_start(4'd1);
    wait_motion("e_track");
    step();
    chk("e_err_x_old", 32'(err_x), 32'h00100);
    chk("e_err_y_old", 32'(err_y), 32'h00200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("e_abort_busy", 32'(busy), 0);
    chk("e_abort_motion", 32'(motion), 0);
    chk("e_abort_fault", 32'(fault), 0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_x = 17'h00321; wr_y = 17'h00200; wr_z = '0;
    start = 1'b1; wp_count = 4'd1;
    step();
    wr_en = 1'b0; start = 1'b0;
    wait_motion("e_track2");
    step();
    chk("e_err_x_new", 32'(err_x), 32'h00321);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Zero waypoint count
    pulse_start(4'd0);
    chk("f_done", 32'(done), 1);
    chk("f_busy", 32'(busy), 0);
    chk("f_motion", 32'(motion), 0);

    // Reset during TRACK of waypoint 1
    pulse_start(4'd3);
    wait_motion("g_track0");
    chk("g_index0", 32'(idx), 0);
    k = 0;
    while (motion === 1'b1 && k < 40) begin step(); k++; end
    wait_motion("g_track1");
    chk("g_index1", 32'(idx), 1);
    step();
    chk("g_err_x", 32'(err_x), 32'h0FF00);
    rst = 1'b1;
    step();
    chk("g_motion", 32'(motion), 0);
    chk("g_busy", 32'(busy), 0);
    chk("g_index", 32'(idx), 0);
    chk("g_err_x_rst", 32'(err_x), 0);
    chk("g_done", 32'(done), 0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/waypoint_sequencer.md
# waypoint_sequencer

Steps the robot through a programmable list of target poses (X, Y, theta). For each waypoint it computes the sign-magnitude pose error fed to the error-control stage. It also watches the velocity command returned by that stage, advancing when the command has been all-zero for a settle window and faulting if a waypoint is not reached in time. It sits between odometry/pose estimation and the error-control/kinematics datapath.

## Interface
- N_WIDTH, 17, word width; sign-magnitude, bit N_WIDTH-1 = sign, lower 16 bits = Q8.8 magnitude
- DEPTH, 8, waypoint table entries
- ADDR_W, 3, table address width (log2 DEPTH)
- SETTLE_CYCLES, 50000, consecutive zero-command cycles required to accept a waypoint (min 4)
- TIMEOUT_CYCLES, 500000000, max cycles in TRACK per waypoint before FAULT; 32-bit counter

- WAYPOINT_SEQUENCER_CLOCK_50  in  1  system clock; only clock
- WAYPOINT_SEQUENCER_RESET_InHigh  in  1  synchronous, active-high reset
- WAYPOINT_SEQUENCER_START_In  in  1  one-cycle start/restart pulse
- WAYPOINT_SEQUENCER_ABORT_In  in  1  one-cycle abort pulse
- WAYPOINT_SEQUENCER_WP_COUNT_InBus  in  ADDR_W+1  number of waypoints, sampled on accepted START
- WAYPOINT_SEQUENCER_WR_EN_In  in  1  table write strobe
- WAYPOINT_SEQUENCER_WR_ADDR_InBus  in  ADDR_W  table write address
- WAYPOINT_SEQUENCER_WR_X/Y/Z_InBus  in  N_WIDTH each  target pose to write
- WAYPOINT_SEQUENCER_POSE_X/Y/Z_InBus  in  N_WIDTH each  current pose
- WAYPOINT_SEQUENCER_VX/VY/WZ_InBus  in  N_WIDTH each  velocity command from error control
- WAYPOINT_SEQUENCER_ERR_X/Y/Z_OutBus  out  N_WIDTH each  registered error, target minus pose
- WAYPOINT_SEQUENCER_MOTION_EN_Out  out  1  high only in TRACK
- WAYPOINT_SEQUENCER_INDEX_OutBus  out  ADDR_W  current waypoint index
- WAYPOINT_SEQUENCER_BUSY_Out  out  1  high in LOAD, TRACK, ADVANCE
- WAYPOINT_SEQUENCER_DONE_Out  out  1  high in DONE
- WAYPOINT_SEQUENCER_FAULT_Out  out  1  high in FAULT

## Operation
- States: IDLE, LOAD, TRACK, ADVANCE, DONE, FAULT.
- IDLE:
  - START -> LOAD, index=0, count latched.
  - Latched count 0 -> DONE directly.
  - Count > DEPTH is clamped to DEPTH.
- LOAD: target registers <- table[index]; settle and timeout counters cleared; -> TRACK.
- TRACK:
  - Each cycle ERR_* <= target - pose.
  - Settle counter increments when VX, VY and WZ magnitudes are all zero; a negative zero counts as zero.
  - Settle counter clears on any nonzero magnitude.
  - Settle counter is held at 0 on the first TRACK cycle, while ERR_* is not yet valid.
  - Settle counter == SETTLE_CYCLES -> ADVANCE.
  - Timeout counter == TIMEOUT_CYCLES -> FAULT; timeout wins if both fire in the same cycle.
- ADVANCE: if index == count-1 -> DONE, else index+1 -> LOAD.
- DONE / FAULT:
  - Hold; index frozen.
  - START -> restart from index 0 via LOAD, count re-latched.
- ABORT in any state -> IDLE, index 0; ABORT wins over a simultaneous START.
- Table writes accepted only in IDLE, DONE and FAULT; ignored while BUSY.
- A write and a START in the same IDLE cycle: the write completes first, and LOAD reads the new data.
- Table contents are not cleared by reset.
- Error arithmetic:
  - Convert both operands to 18-bit two's complement and subtract.
  - Convert the result back to sign-magnitude, saturating the magnitude at 0xFFFF.
  - A zero result always has sign 0.
- Outside TRACK, ERR_* = 0 and MOTION_EN = 0.

## Timing
- Reset: state IDLE; index 0; counters 0; all outputs 0.
- START sampled at edge t: LOAD during cycle t+1, TRACK from t+2.
- First valid ERR_* in cycle t+3; MOTION_EN high from t+2.
- ERR_* lag the pose inputs by exactly 1 cycle.
- Settle: ADVANCE entered 1 cycle after the counter reaches SETTLE_CYCLES; LOAD of the next waypoint follows 1 cycle later.
- Minimum dwell per waypoint is SETTLE_CYCLES+3 cycles.
- Reset asserted mid-operation: IDLE on the next edge; outputs 0 that cycle.
- Pulses longer than 1 cycle: START is edge-insensitive and re-triggers only in IDLE, DONE or FAULT; ABORT held high keeps the block in IDLE.

## Test plan
- Write table[0] = X 0x00100, Y 0x00200, Z 0; pose 0; count 1; START -> ERR_X = 0x00100, ERR_Y = 0x00200 at t+3; MOTION_EN = 1.
- Same setup, force V* = 0 -> DONE after exactly SETTLE_CYCLES+3 cycles; ERR_* = 0 and MOTION_EN = 0 in DONE.
- Three waypoints, V* zero -> INDEX steps 0, 1, 2 then DONE.
- During waypoint 1, inject one nonzero VX cycle mid-settle -> settle counter restarts; advance delayed accordingly.
- Arithmetic:
  - Target 0x0FF00, pose 0x1FF00 -> ERR = 0x0FFFF (saturated).
  - Target 0x10000, pose 0 -> ERR = 0x00000 (sign 0).
- V* held nonzero -> FAULT after TIMEOUT_CYCLES (use a reduced parameter).
- Writes while BUSY are ignored.
- Simultaneous START and ABORT -> IDLE.
- Mid-TRACK reset -> all outputs 0 the next cycle.
